// File: rtl/req_arbiter_4ch_hold.sv
// Four-requester arbiter with grant hold and MAX_HOLD timeout revocation.
// Optional macro ARB_ROUND_ROBIN_EN swaps fixed highest-index priority for round-robin.
module req_arbiter_4ch_hold #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;
  localparam bit          TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic [N_REQ-1:0]  gnt_nxt;
  logic [ID_W-1:0]   gnt_id_nxt;
  logic              timeout_nxt;
  logic              grant_evt;
  logic [N_REQ-1:0]  cand;
  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic              expire;

  // Current owner is never a candidate; gnt is zero in IDLE so this also covers first arbitration.
  assign cand   = req & ~gnt;
  assign expire = TIMEOUT_EN && req[gnt_id] && (hold_cnt == HOLD_LAST);

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_id;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    logic [ID_W-1:0] idx;
    win_found = |cand;
    win_id    = '0;
    idx       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = last_id + ID_W'(k);
      if (cand[idx]) win_id = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_id <= ID_W'(N_REQ - 1);
    end else if (grant_evt) begin
      last_id <= gnt_id_nxt;
    end
  end
`else
  // Fixed priority: highest set index wins.
  always_comb begin
    win_found = |cand;
    win_id    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (cand[i]) win_id = ID_W'(i);
    end
  end
`endif

  // Next-state and registered-output values.
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    gnt_id_nxt   = gnt_id;
    timeout_nxt  = 1'b0;
    grant_evt    = 1'b0;
    hold_cnt_nxt = hold_cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        hold_cnt_nxt = '0;
        gnt_nxt      = '0;
        gnt_id_nxt   = '0;
        if (win_found) begin
          state_nxt  = BUSY;
          gnt_nxt    = N_REQ'(1) << win_id;
          gnt_id_nxt = win_id;
          grant_evt  = 1'b1;
        end
      end
      BUSY: begin
        if (!req[gnt_id] || expire) begin
          hold_cnt_nxt = '0;
          timeout_nxt  = expire;
          if (win_found) begin
            gnt_nxt    = N_REQ'(1) << win_id;
            gnt_id_nxt = win_id;
            grant_evt  = 1'b1;
          end else if (expire) begin
            // Sole requester re-granted after timeout; grant stays continuous.
            grant_evt  = 1'b1;
          end else begin
            state_nxt  = IDLE;
            gnt_nxt    = '0;
            gnt_id_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        gnt_nxt      = '0;
        gnt_id_nxt   = '0;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      gnt_valid <= |gnt_nxt;
      timeout   <= timeout_nxt;
      hold_cnt  <= hold_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_req_arbiter_4ch_hold.sv
// Self-checking bench for req_arbiter_4ch_hold using three instances (MAX_HOLD 4, 3, 1).
module tb_req_arbiter_4ch_hold;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       to;
  } vec_t;

  typedef struct {
    int         inst;
    int         tag;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_a, req_b, req_c;
  logic [3:0] gnt_a, gnt_b, gnt_c;
  logic [1:0] id_a, id_b, id_c;
  logic       val_a, val_b, val_c;
  logic       to_a, to_b, to_c;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t tbl[20];

  always #5 clk = ~clk;

  req_arbiter_4ch_hold #(.MAX_HOLD(4), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_id(id_a),
    .gnt_valid(val_a), .timeout(to_a));
  req_arbiter_4ch_hold #(.MAX_HOLD(3), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_id(id_b),
    .gnt_valid(val_b), .timeout(to_b));
  req_arbiter_4ch_hold #(.MAX_HOLD(1), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .gnt_id(id_c),
    .gnt_valid(val_c), .timeout(to_c));

  task automatic chk(input string nm, input int tag, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", nm, tag, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the addressed instance.
  task automatic check_one();
    exp_t       e;
    logic [3:0] g;
    logic [1:0] i;
    logic       v, t;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    case (e.inst)
      0:       begin g = gnt_a; i = id_a; v = val_a; t = to_a; end
      1:       begin g = gnt_b; i = id_b; v = val_b; t = to_b; end
      default: begin g = gnt_c; i = id_c; v = val_c; t = to_c; end
    endcase
    chk("gnt",       e.tag, g,          e.gnt);
    chk("gnt_id",    e.tag, {2'b00, i}, {2'b00, e.id});
    chk("gnt_valid", e.tag, {3'b000, v}, {3'b000, |e.gnt});
    chk("timeout",   e.tag, {3'b000, t}, {3'b000, e.to});
  endtask

  task automatic step(input int inst, input logic r, input logic [3:0] rq,
                      input logic [3:0] eg, input logic [1:0] ei, input logic et, input int tag);
    exp_t e;
    @(negedge clk);
    rst = r;
    case (inst)
      0:       req_a = rq;
      1:       req_b = rq;
      default: req_c = rq;
    endcase
    e.inst = inst; e.tag = tag; e.gnt = eg; e.id = ei; e.to = et;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_one();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_run;
    // Reset, reset mid-grant, release, priority/no pre-emption, timeouts at MAX_HOLD=4.
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0};
    tbl[2]  = '{1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, 4'b0011, 4'b0010, 2'd1, 1'b0};
    tbl[6]  = '{1'b0, 4'b1011, 4'b0010, 2'd1, 1'b0};
    tbl[7]  = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b0};
    tbl[8]  = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b0};
    tbl[9]  = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b0};
    tbl[10] = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b0};
    tbl[11] = '{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1};
    tbl[12] = '{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b0};
    tbl[13] = '{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b0};
    tbl[14] = '{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b0};
    tbl[15] = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1};
    tbl[16] = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b0};
    tbl[17] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[18] = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0};
    tbl[19] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
`ifdef ARB_ROUND_ROBIN_EN
    n_run = 5;
`else
    n_run = 20;
`endif

    rst = 1'b1;
    req_a = '0; req_b = '0; req_c = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < n_run; i++)
      step(0, tbl[i].rst, tbl[i].req, tbl[i].gnt, tbl[i].id, tbl[i].to, i);

    // Sole requester, MAX_HOLD=3: continuous grant, timeout every third edge.
    for (int k = 1; k <= 10; k++)
      step(1, 1'b0, 4'b0100, 4'b0100, 2'd2, (k > 1) && ((k - 1) % 3 == 0), 100 + k);
    step(1, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 111);

`ifdef ARB_ROUND_ROBIN_EN
    // MAX_HOLD=1 with all requesting: rotate 0,1,2,3,0.
    for (int k = 1; k <= 5; k++)
      step(2, 1'b0, 4'b1111, 4'(1) << ((k - 1) % 4), 2'((k - 1) % 4), k > 1, 200 + k);
`else
    // MAX_HOLD=1 with two requesters: alternate 1,0,1,...
    for (int k = 1; k <= 6; k++)
      step(2, 1'b0, 4'b0011, (k % 2 == 1) ? 4'b0010 : 4'b0001,
           (k % 2 == 1) ? 2'd1 : 2'd0, k > 1, 200 + k);
`endif
    step(2, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 210);
    // MAX_HOLD=1 sole owner: held grant, timeout every cycle.
    for (int k = 1; k <= 3; k++)
      step(2, 1'b0, 4'b0010, 4'b0010, 2'd1, k > 1, 220 + k);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
